// File: rtl/instr_pipe_tracker.sv
// Tracks the ID_EX / EX_MEM / MEM_WB stage words and raises stall on load-use hazards.
// Optional feature macro: STALL_COUNT_EN adds a saturating stall-cycle counter.
module instr_pipe_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] if_id_instruction,
    input  logic        if_id_valid,
    input  logic        flush,
    input  logic        freeze,
    output logic [18:0] ID_EX_instruction,
    output logic [18:0] EX_MEM_instruction,
    output logic [18:0] MEM_WB_instruction,
    output logic        ID_EX_alu_B_mux,
    output logic        stall,
    output logic [15:0] stall_count
);

    localparam logic [4:0] OP_LW = 5'b10000;
    localparam logic [4:0] OP_SW = 5'b10001;

    logic [18:0] id_ex_q, id_ex_d;
    logic [18:0] ex_mem_q, ex_mem_d;
    logic [18:0] mem_wb_q, mem_wb_d;
    logic        bmux_q, bmux_d;

    logic [2:0] if_dst, if_a, if_b;
    logic       if_alu, if_imm, if_lw, if_sw;
    logic       rd_a, rd_b, rd_d;
    logic [2:0] idex_dst, exmem_dst;
    logic       idex_lw, exmem_lw;
    logic       haz1, haz2;

    // Decode the IF/ID consumer and the two load producers ahead of it.
    always_comb begin
        if_dst    = if_id_instruction[13:11];
        if_a      = if_id_instruction[10:8];
        if_b      = if_id_instruction[7:5];
        if_alu    = ~if_id_instruction[18];
        if_imm    = if_id_instruction[17];
        if_lw     = (if_id_instruction[18:14] == OP_LW);
        if_sw     = (if_id_instruction[18:14] == OP_SW);
        rd_a      = if_id_valid & (if_alu | if_lw | if_sw);
        rd_b      = if_id_valid & if_alu & ~if_imm;
        rd_d      = if_id_valid & if_sw;
        idex_dst  = id_ex_q[13:11];
        exmem_dst = ex_mem_q[13:11];
        idex_lw   = (id_ex_q[18:14] == OP_LW) & (idex_dst != 3'd0);
        exmem_lw  = (ex_mem_q[18:14] == OP_LW) & (exmem_dst != 3'd0);
        haz1 = idex_lw & ((rd_a & (if_a == idex_dst))
                        | (rd_b & (if_b == idex_dst))
                        | (rd_d & (if_dst == idex_dst)));
        haz2 = if_id_valid & (if_lw | if_sw) & exmem_lw
             & ((if_a == exmem_dst) | (if_sw & (if_dst == exmem_dst)));
        stall = (haz1 | haz2) & ~freeze & ~flush;
    end

    // Next stage words: freeze holds, flush/stall/invalid inject a bubble.
    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        bmux_d   = bmux_q;
        if (!freeze) begin
            if (flush || stall || !if_id_valid) begin
                id_ex_d = '0;
            end else begin
                id_ex_d = if_id_instruction;
            end
            ex_mem_d = id_ex_q;
            mem_wb_d = ex_mem_q;
            bmux_d   = id_ex_d[17];
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            bmux_q   <= 1'b0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            bmux_q   <= bmux_d;
        end
    end

    assign ID_EX_instruction  = id_ex_q;
    assign EX_MEM_instruction = ex_mem_q;
    assign MEM_WB_instruction = mem_wb_q;
    assign ID_EX_alu_B_mux    = bmux_q;

`ifdef STALL_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of stall cycles; stall is already 0 under freeze.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_instr_pipe_tracker.sv
// Directed bench for instr_pipe_tracker: flow, load-use stalls, flush, freeze, reset.
// Expected counter values follow STALL_COUNT_EN when it is defined.
module tb_instr_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] if_id_instruction;
    logic        if_id_valid;
    logic        flush;
    logic        freeze;
    logic [18:0] ID_EX_instruction;
    logic [18:0] EX_MEM_instruction;
    logic [18:0] MEM_WB_instruction;
    logic        ID_EX_alu_B_mux;
    logic        stall;
    logic [15:0] stall_count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef STALL_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [4:0] ALU  = 5'b00000;
    localparam logic [4:0] ALUI = 5'b01000;
    localparam logic [4:0] LW   = 5'b10000;
    localparam logic [4:0] SW   = 5'b10001;

    instr_pipe_tracker dut (
        .clk                (clk),
        .rst                (rst),
        .if_id_instruction  (if_id_instruction),
        .if_id_valid        (if_id_valid),
        .flush              (flush),
        .freeze             (freeze),
        .ID_EX_instruction  (ID_EX_instruction),
        .EX_MEM_instruction (EX_MEM_instruction),
        .MEM_WB_instruction (MEM_WB_instruction),
        .ID_EX_alu_B_mux    (ID_EX_alu_B_mux),
        .stall              (stall),
        .stall_count        (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b, 5'b00000};
    endfunction

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [18:0] w,
                         input logic fl, input logic fz);
        if_id_valid       = v;
        if_id_instruction = w;
        flush             = fl;
        freeze            = fz;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [18:0] w1, w2, w3, lw2, alu_r2, sw_r2;

    initial begin
        w1     = mk(ALU, 3'd1, 3'd2, 3'd3);
        w2     = mk(ALU, 3'd4, 3'd5, 3'd6);
        w3     = mk(ALUI, 3'd7, 3'd1, 3'd0);
        lw2    = mk(LW, 3'd2, 3'd1, 3'd0);
        alu_r2 = mk(ALU, 3'd3, 3'd2, 3'd1);
        sw_r2  = mk(SW, 3'd2, 3'd1, 3'd0);

        // Reset wins over a valid load in IF/ID.
        rst = 1'b1;
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, alu_r2, 1'b0, 1'b0);
        chk("rst_idex", ID_EX_instruction, '0);
        chk("rst_exmem", EX_MEM_instruction, '0);
        chk("rst_memwb", MEM_WB_instruction, '0);
        chk("rst_bmux", 19'(ID_EX_alu_B_mux), '0);
        chk("rst_stall", 19'(stall), '0);
        chk("rst_cnt", 19'(stall_count), '0);

        // Three independent ALU words flow through in 3 clocks.
        drive(1'b1, w1, 1'b0, 1'b0);
        chk("flow_stall1", 19'(stall), '0);
        tick();
        chk("flow_idex1", ID_EX_instruction, w1);
        drive(1'b1, w2, 1'b0, 1'b0);
        tick();
        chk("flow_exmem2", EX_MEM_instruction, w1);
        drive(1'b1, w3, 1'b0, 1'b0);
        chk("flow_stall3", 19'(stall), '0);
        tick();
        chk("flow_memwb3", MEM_WB_instruction, w1);
        chk("flow_idex3", ID_EX_instruction, w3);
        chk("flow_bmux3", 19'(ID_EX_alu_B_mux), 19'd1);
        idle(1);
        chk("flow_bubble", ID_EX_instruction, '0);
        chk("flow_bmux0", 19'(ID_EX_alu_B_mux), '0);
        idle(2);

        // Load then dependent ALU: one stall cycle.
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b1, alu_r2, 1'b0, 1'b0);
        chk("lu_stall", 19'(stall), 19'd1);
        tick();
        chk("lu_bubble", ID_EX_instruction, '0);
        chk("lu_exmem", EX_MEM_instruction, lw2);
        chk("lu_stall2", 19'(stall), '0);
        tick();
        chk("lu_enter", ID_EX_instruction, alu_r2);
        chk("lu_cnt", 19'(stall_count), CNT_ON ? 19'd1 : 19'd0);
        idle(3);

        // Load then store of the loaded register: two stall cycles.
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b1, sw_r2, 1'b0, 1'b0);
        chk("ls_stall_d1", 19'(stall), 19'd1);
        tick();
        chk("ls_bubble1", ID_EX_instruction, '0);
        chk("ls_stall_d2", 19'(stall), 19'd1);
        tick();
        chk("ls_bubble2", ID_EX_instruction, '0);
        chk("ls_memwb", MEM_WB_instruction, lw2);
        chk("ls_stall_end", 19'(stall), '0);
        tick();
        chk("ls_enter", ID_EX_instruction, sw_r2);
        chk("ls_cnt", 19'(stall_count), CNT_ON ? 19'd3 : 19'd0);
        idle(3);

        // r0 is never a hazard; immediate ALU ignores its B field.
        drive(1'b1, mk(LW, 3'd0, 3'd1, 3'd0), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(ALU, 3'd3, 3'd0, 3'd0), 1'b0, 1'b0);
        chk("r0_stall", 19'(stall), '0);
        idle(3);
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(ALUI, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
        chk("imm_stall", 19'(stall), '0);
        tick();
        chk("imm_idex", ID_EX_instruction, mk(ALUI, 3'd3, 3'd1, 3'd2));
        chk("imm_bmux", 19'(ID_EX_alu_B_mux), 19'd1);
        idle(3);

        // An invalid IF/ID word never stalls.
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b0, alu_r2, 1'b0, 1'b0);
        chk("inv_stall", 19'(stall), '0);
        idle(3);

        // Flush suppresses the stall and injects a bubble.
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b1, alu_r2, 1'b1, 1'b0);
        chk("fl_stall", 19'(stall), '0);
        tick();
        chk("fl_idex", ID_EX_instruction, '0);
        chk("fl_exmem", EX_MEM_instruction, lw2);
        idle(3);

        // Freeze holds everything across the edge.
        drive(1'b1, w1, 1'b0, 1'b0);
        tick();
        drive(1'b1, lw2, 1'b0, 1'b0);
        tick();
        drive(1'b1, alu_r2, 1'b0, 1'b1);
        chk("fz_stall", 19'(stall), '0);
        tick();
        chk("fz_idex", ID_EX_instruction, lw2);
        chk("fz_exmem", EX_MEM_instruction, w1);
        chk("fz_memwb", MEM_WB_instruction, '0);
        chk("fz_bmux", 19'(ID_EX_alu_B_mux), '0);
        chk("fz_cnt", 19'(stall_count), CNT_ON ? 19'd3 : 19'd0);

        // Reset in the middle of a stall discards it.
        drive(1'b1, alu_r2, 1'b0, 1'b0);
        chk("rs_stall_pre", 19'(stall), 19'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_idex", ID_EX_instruction, '0);
        chk("rs_exmem", EX_MEM_instruction, '0);
        chk("rs_stall", 19'(stall), '0);
        chk("rs_cnt", 19'(stall_count), '0);
        tick();
        chk("rs_normal", ID_EX_instruction, alu_r2);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
